mem_port_arbiter: RTL

//  Shares one single-port synchronous SRAM between the fetch requester (I, read-only) and the
//  MEM-stage load/store requester (D). Sits between pc/ir fetch logic, the ex_mem load/store

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_starve_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: read-owner
// encoding and the bus widths used by the CPU top.
package mem_port_arbiter_pkg;

    localparam int CPU_D_WIDTH       = 32;
    localparam int CPU_A_WIDTH       = 32;
    localparam int CPU_MEM_A_WIDTH   = 8;
    localparam int DEF_STARVE_LIMIT  = 4;

    // Which requester owns the read data returning from the SRAM this cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_I = 2'd1,
        RD_D = 2'd2
    } owner_e;

    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating up-counter with synchronous clear; sat flags that the
// count has reached LIMIT.
module starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT,
    parameter int CW    = cnt_width(LIMIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt < CW'(LIMIT))) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign sat = (cnt >= CW'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter: data port has fixed priority, fetch is forced
// through after STARVE_LIMIT consecutive denials. Read data returns 1 cycle later.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int D_WIDTH      = CPU_D_WIDTH,
    parameter int A_WIDTH      = CPU_A_WIDTH,
    parameter int MEM_A_WIDTH  = CPU_MEM_A_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_req,
    input  logic [A_WIDTH-1:0]     i_addr,
    output logic                   i_gnt,
    output logic                   i_rvalid,
    output logic [D_WIDTH-1:0]     i_rdata,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [D_WIDTH/8-1:0]   d_be,
    input  logic [A_WIDTH-1:0]     d_addr,
    input  logic [D_WIDTH-1:0]     d_wdata,
    output logic                   d_gnt,
    output logic                   d_rvalid,
    output logic [D_WIDTH-1:0]     d_rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [D_WIDTH/8-1:0]   mem_be,
    output logic [MEM_A_WIDTH-1:0] mem_addr,
    output logic [D_WIDTH-1:0]     mem_wdata,
    input  logic [D_WIDTH-1:0]     mem_rdata,
    output logic                   starved
);

    owner_e state, state_nxt;
    logic   starve_sat;

    starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (i_req & ~i_gnt),
        .clr (i_gnt | ~i_req),
        .sat (starve_sat)
    );

    // Counter clears on the reset edge; mask it so nothing is forced while rst is high.
    assign starved = starve_sat & ~rst;

    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (starved && i_req) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    // Word index only: byte offset and bits above the SRAM depth wrap.
    always_comb begin
        mem_en    = i_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_be    = '1;
        mem_addr  = '0;
        mem_wdata = '0;
        if (i_gnt) begin
            mem_addr = i_addr[MEM_A_WIDTH+1:2];
        end else if (d_gnt) begin
            mem_addr = d_addr[MEM_A_WIDTH+1:2];
            if (d_we) begin
                mem_be    = d_be;
                mem_wdata = d_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;
        if (i_gnt) begin
            state_nxt = RD_I;
        end else if (d_gnt && !d_we) begin
            state_nxt = RD_D;
        end
        // A read in flight when rst rises is dropped.
        if (!rst) begin
            case (state)
                RD_I: begin
                    i_rvalid = 1'b1;
                    i_rdata  = mem_rdata;
                end
                RD_D: begin
                    d_rvalid = 1'b1;
                    d_rdata  = mem_rdata;
                end
                default: ;
            endcase
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, i_addr[A_WIDTH-1:MEM_A_WIDTH+2], i_addr[1:0],
                                d_addr[A_WIDTH-1:MEM_A_WIDTH+2], d_addr[1:0]};

endmodule
